memory_access_stage: RTL and testbench

MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

---
 rtl/memory_access_stage_pkg.sv | 15 +
 rtl/memory_bus_master.sv | 85 ++++++++
 rtl/memory_access_stage.sv | 73 +++++++
 tb/tb_memory_access_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_stage_pkg.sv
// Shared widths and bus-master state encoding for the memory access stage.
package memory_access_stage_pkg;

    localparam int BUS_MSB = 31;
    localparam int BUS_W   = BUS_MSB + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } bus_state_t;

    typedef logic [BUS_MSB:0] word_t;

endpackage

// File: rtl/memory_bus_master.sv
// Single-outstanding bus master: issues one load/store, waits for ack
// or timeout, then spends one DONE cycle letting the pipeline advance.
module memory_bus_master
    import memory_access_stage_pkg::*;
#(
    parameter int BUS_TIMEOUT = 15
) (
    input  logic  i_Clk,
    input  logic  i_Rst,
    input  logic  i_Access,
    input  logic  i_IsWrite,
    input  word_t i_Addr,
    input  word_t i_WData,
    input  logic  i_BusAck,
    input  word_t i_BusRData,
    output logic  o_BusReq,
    output logic  o_BusWe,
    output word_t o_BusAddr,
    output word_t o_BusWData,
    output logic  o_BusErr,
    output word_t o_MemData,
    output logic  o_Idle,
    output logic  o_Wait
);

    localparam int CW = $clog2(BUS_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BUS_TIMEOUT - 1);

    bus_state_t    state;
    logic [CW-1:0] cnt;
    logic          timeout;

    assign timeout = (cnt == CNT_LAST);
    assign o_Idle  = (state == ST_IDLE);
    assign o_Wait  = (state == ST_WAIT);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            o_BusReq   <= 1'b0;
            o_BusWe    <= 1'b0;
            o_BusAddr  <= '0;
            o_BusWData <= '0;
            o_MemData  <= '0;
            o_BusErr   <= 1'b0;
        end else begin
            o_BusErr <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_Access) begin
                        o_BusAddr  <= i_Addr;
                        o_BusWData <= i_WData;
                        o_BusWe    <= i_IsWrite;
                        o_BusReq   <= 1'b1;
                        cnt        <= '0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // ack takes priority over a timeout in the same cycle
                    if (i_BusAck) begin
                        if (!o_BusWe) o_MemData <= i_BusRData;
                        o_BusReq <= 1'b0;
                        state    <= ST_DONE;
                    end else if (timeout) begin
                        if (!o_BusWe) o_MemData <= '0;
                        o_BusReq <= 1'b0;
                        o_BusErr <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: combinational pass-through to MEM/WB plus a stalling
// bus master for loads and stores.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int BUS_TIMEOUT = 15
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  word_t       i_ProgramCounter,
    input  logic [4:0]  i_IrRst,
    input  word_t       i_AluOut,
    input  word_t       i_StoreData,
    input  word_t       i_Imm22,
    input  logic        i_WrEnRf,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic [1:0]  i_RfDataInSel,
    output word_t       o_ProgramCounter,
    output logic [4:0]  o_IrRst,
    output word_t       o_AluOut,
    output word_t       o_Imm22,
    output logic        o_WrEnRf,
    output logic [1:0]  o_RfDataInSel,
    output word_t       o_MemData,
    output logic        o_Stall,
    output logic        o_BusReq,
    output logic        o_BusWe,
    output word_t       o_BusAddr,
    output word_t       o_BusWData,
    input  logic        i_BusAck,
    input  word_t       i_BusRData,
    output logic        o_BusErr
);

    logic access;
    logic bm_idle;
    logic bm_wait;

    assign access = i_MemRead | i_MemWrite;

    assign o_ProgramCounter = i_ProgramCounter;
    assign o_IrRst          = i_IrRst;
    assign o_AluOut         = i_AluOut;
    assign o_Imm22          = i_Imm22;
    assign o_WrEnRf         = i_WrEnRf;
    assign o_RfDataInSel    = i_RfDataInSel;

    // DONE is the one non-stalled cycle that lets the pipeline step
    assign o_Stall = ~i_Rst & ((bm_idle & access) | bm_wait);

    memory_bus_master #(
        .BUS_TIMEOUT(BUS_TIMEOUT)
    ) u_bus_master (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Access   (access),
        .i_IsWrite  (i_MemWrite),
        .i_Addr     (i_AluOut),
        .i_WData    (i_StoreData),
        .i_BusAck   (i_BusAck),
        .i_BusRData (i_BusRData),
        .o_BusReq   (o_BusReq),
        .o_BusWe    (o_BusWe),
        .o_BusAddr  (o_BusAddr),
        .o_BusWData (o_BusWData),
        .o_BusErr   (o_BusErr),
        .o_MemData  (o_MemData),
        .o_Idle     (bm_idle),
        .o_Wait     (bm_wait)
    );

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with a request/result scoreboard.
module tb_memory_access_stage;

    logic        i_Clk = 1'b0;
    logic        i_Rst;
    logic [31:0] i_ProgramCounter, i_AluOut, i_StoreData, i_Imm22;
    logic [4:0]  i_IrRst;
    logic        i_WrEnRf, i_MemRead, i_MemWrite;
    logic [1:0]  i_RfDataInSel;
    logic [31:0] o_ProgramCounter, o_AluOut, o_Imm22, o_MemData;
    logic [4:0]  o_IrRst;
    logic        o_WrEnRf;
    logic [1:0]  o_RfDataInSel;
    logic        o_Stall, o_BusReq, o_BusWe, o_BusErr;
    logic [31:0] o_BusAddr, o_BusWData;
    logic        i_BusAck;
    logic [31:0] i_BusRData;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] mem;
        logic        err;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];

    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   req_seen  = 0;
    logic prev_req  = 1'b0;
    logic rst_edge  = 1'b1;

    always #5 i_Clk = ~i_Clk;

    memory_access_stage #(.BUS_TIMEOUT(15)) dut (
        .i_Clk            (i_Clk),
        .i_Rst            (i_Rst),
        .i_ProgramCounter (i_ProgramCounter),
        .i_IrRst          (i_IrRst),
        .i_AluOut         (i_AluOut),
        .i_StoreData      (i_StoreData),
        .i_Imm22          (i_Imm22),
        .i_WrEnRf         (i_WrEnRf),
        .i_MemRead        (i_MemRead),
        .i_MemWrite       (i_MemWrite),
        .i_RfDataInSel    (i_RfDataInSel),
        .o_ProgramCounter (o_ProgramCounter),
        .o_IrRst          (o_IrRst),
        .o_AluOut         (o_AluOut),
        .o_Imm22          (o_Imm22),
        .o_WrEnRf         (o_WrEnRf),
        .o_RfDataInSel    (o_RfDataInSel),
        .o_MemData        (o_MemData),
        .o_Stall          (o_Stall),
        .o_BusReq         (o_BusReq),
        .o_BusWe          (o_BusWe),
        .o_BusAddr        (o_BusAddr),
        .o_BusWData       (o_BusWData),
        .i_BusAck         (i_BusAck),
        .i_BusRData       (i_BusRData),
        .o_BusErr         (o_BusErr)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    always @(posedge i_Clk) rst_edge <= i_Rst;

    // Scoreboard: new request on rising o_BusReq, result on its fall
    always @(negedge i_Clk) begin
        if (o_BusReq && !prev_req) begin
            req_seen++;
            if (req_q.size() == 0) begin
                check("unexpected_req", 32'd1, 32'd0);
            end else begin
                req_t r;
                r = req_q.pop_front();
                check("bus_addr", o_BusAddr, r.addr);
                check("bus_we", {31'd0, o_BusWe}, {31'd0, r.we});
                if (r.we) check("bus_wdata", o_BusWData, r.wdata);
            end
        end
        if (!o_BusReq && prev_req && !rst_edge) begin
            if (res_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = res_q.pop_front();
                check("mem_data", o_MemData, e.mem);
                check("bus_err", {31'd0, o_BusErr}, {31'd0, e.err});
            end
        end
        prev_req <= o_BusReq;
    end

    // ack_wait: WAIT cycle (1-based) in which ack arrives, 0 = never
    task automatic access(input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_wait,
                          input logic [31:0] exp_mem, input logic exp_err);
        int c;
        int stalls;
        int reqs;
        req_t r;
        res_t e;
        step();
        i_MemRead   = rd;
        i_MemWrite  = wr;
        i_AluOut    = addr;
        i_StoreData = wdata;
        r.we = wr; r.addr = addr; r.wdata = wdata;
        e.mem = exp_mem; e.err = exp_err;
        req_q.push_back(r);
        res_q.push_back(e);
        #1;
        check("stall_idle_access", {31'd0, o_Stall}, 32'd1);
        c = 0; stalls = 0; reqs = 0;
        while (o_Stall && c < 40) begin
            stalls++;
            reqs += int'(o_BusReq);
            step();
            c++;
            i_BusAck   = (c == ack_wait);
            i_BusRData = rdata;
            #1;
        end
        check("stall_cycles", stalls, 1 + (ack_wait != 0 ? ack_wait : 15));
        check("req_cycles", reqs, (ack_wait != 0 ? ack_wait : 15));
        check("done_no_req", {31'd0, o_BusReq}, 32'd0);
        i_BusAck   = 1'b0;
        i_MemRead  = 1'b0;
        i_MemWrite = 1'b0;
    endtask

    initial begin
        int seen0;
        i_Rst = 1'b1;
        i_ProgramCounter = 32'h0; i_IrRst = 5'd0; i_AluOut = 32'h0;
        i_StoreData = 32'h0; i_Imm22 = 32'h0; i_WrEnRf = 1'b0;
        i_MemRead = 1'b1; i_MemWrite = 1'b0; i_RfDataInSel = 2'd0;
        i_BusAck = 1'b0; i_BusRData = 32'h0;
        step();
        step();
        check("rst_stall", {31'd0, o_Stall}, 32'd0);
        check("rst_req", {31'd0, o_BusReq}, 32'd0);
        check("rst_we", {31'd0, o_BusWe}, 32'd0);
        check("rst_addr", o_BusAddr, 32'd0);
        check("rst_wdata", o_BusWData, 32'd0);
        check("rst_memdata", o_MemData, 32'd0);
        check("rst_err", {31'd0, o_BusErr}, 32'd0);
        i_MemRead = 1'b0;
        i_Rst = 1'b0;

        // ALU op, no access
        i_AluOut = 32'h1234; i_ProgramCounter = 32'h40; i_IrRst = 5'd7;
        i_Imm22 = 32'hFFFF_FFF0; i_WrEnRf = 1'b1; i_RfDataInSel = 2'd2;
        #1;
        check("pt_aluout", o_AluOut, 32'h1234);
        check("pt_pc", o_ProgramCounter, 32'h40);
        check("pt_irrst", {27'd0, o_IrRst}, 32'd7);
        check("pt_imm", o_Imm22, 32'hFFFF_FFF0);
        check("pt_wren", {31'd0, o_WrEnRf}, 32'd1);
        check("pt_sel", {30'd0, o_RfDataInSel}, 32'd2);
        for (int i = 0; i < 3; i++) begin
            check("alu_no_stall", {31'd0, o_Stall}, 32'd0);
            step();
        end

        // Ack during IDLE is ignored
        i_BusAck = 1'b1; i_BusRData = 32'hBAD0_BAD0;
        step();
        i_BusAck = 1'b0;
        check("idle_ack_req", {31'd0, o_BusReq}, 32'd0);
        check("idle_ack_mem", o_MemData, 32'd0);

        access(1'b1, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2,
               32'hDEAD_BEEF, 1'b0);
        access(1'b0, 1'b1, 32'h200, 32'h55AA, 32'h1111_2222, 1,
               32'hDEAD_BEEF, 1'b0);
        access(1'b1, 1'b1, 32'h204, 32'hA5A5, 32'h3333_4444, 3,
               32'hDEAD_BEEF, 1'b0);
        access(1'b1, 1'b0, 32'h300, 32'h0, 32'hCAFE_F00D, 0,
               32'h0, 1'b1);
        step();
        check("err_one_pulse", {31'd0, o_BusErr}, 32'd0);
        check("idle_after_err", {31'd0, o_Stall}, 32'd0);

        // Ack exactly on the last WAIT cycle beats the timeout
        access(1'b1, 1'b0, 32'h310, 32'h0, 32'h0BAD_F00D, 15,
               32'h0BAD_F00D, 1'b0);

        // Back-to-back loads, immediate acks
        seen0 = req_seen;
        access(1'b1, 1'b0, 32'h400, 32'h0, 32'h0000_AAAA, 1,
               32'h0000_AAAA, 1'b0);
        check("b2b_gap", {31'd0, o_Stall}, 32'd0);
        access(1'b1, 1'b0, 32'h404, 32'h0, 32'h0000_BBBB, 1,
               32'h0000_BBBB, 1'b0);
        step();
        check("b2b_two_reqs", req_seen - seen0, 32'd2);

        // Reset in the 2nd WAIT cycle, late ack afterwards
        i_MemRead = 1'b1; i_AluOut = 32'h500;
        req_q.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'h0});
        step();
        step();
        i_Rst = 1'b1;
        #1;
        check("rst_cycle_stall", {31'd0, o_Stall}, 32'd0);
        step();
        i_Rst = 1'b0; i_MemRead = 1'b0;
        i_BusAck = 1'b1; i_BusRData = 32'h7777_7777;
        #1;
        check("midrst_req", {31'd0, o_BusReq}, 32'd0);
        check("midrst_stall", {31'd0, o_Stall}, 32'd0);
        check("midrst_mem", o_MemData, 32'd0);
        step();
        i_BusAck = 1'b0;
        check("late_ack_req", {31'd0, o_BusReq}, 32'd0);
        check("late_ack_mem", o_MemData, 32'd0);
        step();
        check("req_q_empty", req_q.size(), 32'd0);
        check("res_q_empty", res_q.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
